irq_ctrl: RTL and testbench
===========================

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4: number of interrupt sources, legal range 1..31.
REQ-002 SHALL have parameter BASE, default 32'h0000_0000: register window base, 16-byte aligned.
REQ-003 SHALL have port Clk  input  1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port Rst  input  1: reset, asynchronous and active-high.
REQ-005 SHALL have port src_i  input  NUM_SRC: interrupt sources (Int_UART, Int_Timer, Int_Timer1, ...), synchronous to Clk.
REQ-006 SHALL have port req  input  1: CPU data-bus request.
REQ-007 SHALL have port we  input  1: write enable, qualified by req.
REQ-008 SHALL have port be  input  4: byte enables for writes.
REQ-009 SHALL have port addr  input  32: byte address.
REQ-010 SHALL have port wdata  input  32: write data.
REQ-011 SHALL have port gnt  output  1: request accepted.
REQ-012 SHALL have port rvalid  output  1: response valid.
REQ-013 SHALL have port rdata  output  32: read data, valid with rvalid.
REQ-014 SHALL have port err  output  1: error response, valid with rvalid.
REQ-015 SHALL have port irq_o  output  1: aggregated interrupt to core irq_external_i.
REQ-016 SHALL have port irq_id_o  output  5: ID of highest-priority active source, 0 = none.

Function
REQ-017 SHALL select when req=1 and addr[31:4]==BASE[31:4]; gnt = select, combinational, same cycle; otherwise gnt=0 and no state change.
REQ-018 SHALL assert rvalid for exactly one cycle, on the cycle after each grant, for reads and writes; rdata=0 on writes and on err.
REQ-019 SHALL map offsets: 0x0 PENDING, 0x4 ENABLE (RW), 0x8 EDGE (RW; 1=rising-edge, 0=level), 0xC CLAIM (RO).
REQ-020 SHALL implement bits [NUM_SRC-1:0] only; unimplemented bits read 0, writes ignored.
REQ-021 SHALL apply writes per byte lane per be; be=0 write is a legal no-op with err=0.
REQ-022 SHALL keep prev[i] register tracking src_i[i] each cycle.
REQ-023 Edge source (EDGE[i]=1): PENDING[i] set on the clock where src_i[i]=1 and prev[i]=0; cleared by write-1 to PENDING[i] or by CLAIM read returning i+1.
REQ-024 Level source (EDGE[i]=0): PENDING[i] loads src_i[i] every cycle; writes and claims have no effect on it.
REQ-025 Simultaneous set and clear (W1C or claim) on the same bit in the same cycle: set wins, PENDING[i]=1.
REQ-026 Switching EDGE[i] SHALL NOT itself set or clear PENDING[i]; new mode applies from the next cycle.
REQ-027 SHALL drive irq_o = |(PENDING & ENABLE), combinational from registers: edge at src_i sampled at clock k gives irq_o=1 after clock k (1-cycle latency).
REQ-028 SHALL drive irq_id_o = lowest index i with PENDING[i]&ENABLE[i], plus 1; 0 if none; lowest index is highest priority.
REQ-029 CLAIM read SHALL return irq_id_o value at grant cycle in rdata[4:0] at rvalid; side-effect clear occurs at the grant clock.
REQ-030 Write to CLAIM SHALL produce err=1 with rvalid and change no state.
REQ-031 Masked (ENABLE[i]=0) sources SHALL still latch PENDING; enabling later raises irq_o the same cycle ENABLE updates.
REQ-032 Back-to-back requests on consecutive cycles SHALL each be granted; one response per grant, in order.

Reset
REQ-033 Rst=1 SHALL asynchronously clear PENDING, ENABLE, EDGE, prev, rvalid, rdata, err; gnt follows REQ-017 but no access completes during reset.
REQ-034 Outputs during and after reset: irq_o=0, irq_id_o=0, rvalid=0, err=0, rdata=0.
REQ-035 Source held high across reset release SHALL register as an edge on the first clock (prev resets to 0).
REQ-036 Reset mid-access SHALL drop the pending response; no rvalid after reset release for a pre-reset grant.

Verification
REQ-037 ENABLE=0x3, EDGE=0x1; pulse src_i[0] one cycle -> PENDING=0x1, irq_o=1 next cycle, irq_id_o=1; read CLAIM -> rdata=1, PENDING=0, irq_o=0.
REQ-038 EDGE=0, ENABLE=0x2; hold src_i[1]=1 -> irq_id_o=2; write PENDING=0xF -> PENDING stays 0x2; drop src_i[1] -> irq_o=0 one cycle later.
REQ-039 EDGE=0xF, ENABLE=0xF; edges on src 2 and 3 same cycle -> irq_id_o=3; claim -> 3, then irq_id_o=4; claim -> 4, irq_o=0.
REQ-040 Edge on src_i[0] in same cycle as W1C of bit 0 -> PENDING[0]=1 after the clock.
REQ-041 Write CLAIM -> rvalid=1, err=1, registers unchanged; access addr BASE+0x10 -> gnt=0, no rvalid.
REQ-042 Write ENABLE with be=4'b0010, wdata=0xFFFF_FFFF -> ENABLE unchanged in bits [7:0]; assert Rst mid-read -> rvalid=0, all registers 0.

Source files
------------

// File: rtl/irq_ctrl_if.sv
// Data-bus port of the interrupt controller:
// request/grant plus a one-cycle-later response.
interface irq_ctrl_if;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt aggregator: per-source pending/enable/edge
// registers, fixed lowest-index priority and a claim register.
module irq_ctrl #(
    parameter int          NUM_SRC = 4,
    parameter logic [31:0] BASE    = 32'h0000_0000
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic [NUM_SRC-1:0] src_i,
    irq_ctrl_if.slave          bus,
    output logic               irq_o,
    output logic [4:0]         irq_id_o
);
    typedef enum logic [1:0] {
        OFF_PEND  = 2'd0,
        OFF_EN    = 2'd1,
        OFF_EDGE  = 2'd2,
        OFF_CLAIM = 2'd3
    } off_t;

    logic               sel;
    logic               wr;
    logic               rd;
    off_t               off;
    logic [31:0]        m32;
    logic [31:0]        rv;
    logic [NUM_SRC-1:0] wm;
    logic [NUM_SRC-1:0] wbits;
    logic [NUM_SRC-1:0] pend;
    logic [NUM_SRC-1:0] pend_n;
    logic [NUM_SRC-1:0] en;
    logic [NUM_SRC-1:0] edge_mode;
    logic [NUM_SRC-1:0] prev;
    logic [NUM_SRC-1:0] act;
    logic [NUM_SRC-1:0] w1c;
    logic [NUM_SRC-1:0] claim_clr;
    logic               unused_bits;

    assign sel = bus.req
              && (bus.addr[31:4] == BASE[31:4]);
    assign bus.gnt = sel;
    assign off = off_t'(bus.addr[3:2]);
    assign wr  = sel && bus.we;
    assign rd  = sel && !bus.we;

    assign m32 = {{8{bus.be[3]}}, {8{bus.be[2]}},
                  {8{bus.be[1]}}, {8{bus.be[0]}}};
    assign wm    = m32[NUM_SRC-1:0];
    assign wbits = bus.wdata[NUM_SRC-1:0] & wm;
    assign unused_bits = ^{bus.addr[1:0], bus.wdata, m32};

    assign act   = pend & en;
    assign irq_o = |act;

    always_comb begin
        irq_id_o = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (act[i]) irq_id_o = 5'(i + 1);
        end
    end

    // Set term is OR-ed last so a same-cycle edge beats any clear.
    always_comb begin
        w1c       = '0;
        claim_clr = '0;
        pend_n    = pend;
        if (wr && off == OFF_PEND) w1c = wbits;
        for (int i = 0; i < NUM_SRC; i++) begin
            claim_clr[i] = rd && off == OFF_CLAIM
                        && irq_id_o == 5'(i + 1);
            if (edge_mode[i])
                pend_n[i] = (src_i[i] && !prev[i])
                         || (pend[i] && !w1c[i]
                             && !claim_clr[i]);
            else
                pend_n[i] = src_i[i];
        end
    end

    always_comb begin
        rv = '0;
        unique case (off)
            OFF_PEND:  rv = 32'(pend);
            OFF_EN:    rv = 32'(en);
            OFF_EDGE:  rv = 32'(edge_mode);
            OFF_CLAIM: rv = 32'(irq_id_o);
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            prev       <= '0;
            pend       <= '0;
            en         <= '0;
            edge_mode  <= '0;
            bus.rvalid <= 1'b0;
            bus.err    <= 1'b0;
            bus.rdata  <= '0;
        end else begin
            prev <= src_i;
            pend <= pend_n;
            if (wr && off == OFF_EN)
                en <= (en & ~wm) | wbits;
            if (wr && off == OFF_EDGE)
                edge_mode <= (edge_mode & ~wm) | wbits;
            bus.rvalid <= sel;
            bus.err    <= wr && off == OFF_CLAIM;
            bus.rdata  <= rd ? rv : '0;
        end
    end
endmodule

// File: tb/tb_irq_ctrl.sv
// Directed vector bench for irq_ctrl: table of bus/source
// stimulus with hand-computed responses, plus reset corners.
module tb_irq_ctrl;
    localparam logic [31:0] B = 32'h0000_1000;

    logic       Clk = 1'b0;
    logic       Rst;
    logic [3:0] src;
    logic       irq;
    logic [4:0] id;
    int         n_vec = 0;
    int         n_bad = 0;

    irq_ctrl_if bus ();

    irq_ctrl #(
        .NUM_SRC (4),
        .BASE    (B)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .src_i    (src),
        .bus      (bus),
        .irq_o    (irq),
        .irq_id_o (id)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  src;
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        err;
        logic        irq;
        logic [4:0]  id;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        logic req, logic we, logic [3:0] be,
        logic [31:0] addr, logic [31:0] wdata,
        logic [3:0] s, logic g, logic rv,
        logic [31:0] rd, logic e, logic q,
        logic [4:0] i
    );
        vec_t v;
        v.req = req;  v.we = we;  v.be = be;
        v.addr = addr;  v.wdata = wdata;
        v.src = s;  v.gnt = g;  v.rvalid = rv;
        v.rdata = rd;  v.err = e;  v.irq = q;
        v.id = i;
        return v;
    endfunction

    task automatic chk(string name,
                       logic [31:0] act,
                       logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h",
                     name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic rd_chk(string name,
                          logic [31:0] a,
                          logic [31:0] exp);
        bus.req = 1'b1;
        bus.we  = 1'b0;
        bus.be  = 4'hF;
        bus.addr = a;
        #1;
        chk({name, " gnt"}, 32'(bus.gnt), 32'd1);
        tick();
        chk({name, " rvalid"}, 32'(bus.rvalid), 32'd1);
        chk({name, " rdata"}, bus.rdata, exp);
        bus.req = 1'b0;
    endtask

    initial begin
        Rst = 1'b1;
        src = '0;
        bus.req = 1'b0;
        bus.we = 1'b0;
        bus.be = '0;
        bus.addr = '0;
        bus.wdata = '0;
        repeat (2) tick();
        chk("rst rvalid", 32'(bus.rvalid), 32'd0);
        chk("rst err", 32'(bus.err), 32'd0);
        chk("rst rdata", bus.rdata, 32'd0);
        chk("rst irq", 32'(irq), 32'd0);
        chk("rst id", 32'(id), 32'd0);
        Rst = 1'b0;

        // one-shot edge, claim clears it
        tbl.push_back(mk(1,1,4'hF,B+4,3,0, 1,1,0,0,0,0));
        tbl.push_back(mk(1,1,4'hF,B+8,1,0, 1,1,0,0,0,0));
        tbl.push_back(mk(0,0,4'h0,0,0,1, 0,0,0,0,1,1));
        tbl.push_back(mk(1,0,4'hF,B,0,0, 1,1,1,0,1,1));
        tbl.push_back(mk(1,0,4'hF,B+12,0,0, 1,1,1,0,0,0));
        tbl.push_back(mk(1,0,4'hF,B,0,0, 1,1,0,0,0,0));
        // claim write error, out-of-window access
        tbl.push_back(mk(1,1,4'hF,B+12,'1,0, 1,1,0,1,0,0));
        tbl.push_back(mk(1,0,4'hF,B+4,0,0, 1,1,3,0,0,0));
        tbl.push_back(mk(1,0,4'hF,B+16,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(1,0,4'hF,B+8,0,0, 1,1,1,0,0,0));
        // byte lanes
        tbl.push_back(mk(1,1,4'h2,B+4,'1,0, 1,1,0,0,0,0));
        tbl.push_back(mk(1,0,4'hF,B+4,0,0, 1,1,3,0,0,0));
        tbl.push_back(mk(1,1,4'h0,B+4,15,0, 1,1,0,0,0,0));
        tbl.push_back(mk(1,0,4'hF,B+4,0,0, 1,1,3,0,0,0));
        tbl.push_back(mk(1,1,4'h1,B+4,'1,0, 1,1,0,0,0,0));
        tbl.push_back(mk(1,0,4'hF,B+4,0,0, 1,1,15,0,0,0));
        // level sources ignore W1C
        tbl.push_back(mk(1,1,4'hF,B+8,0,0, 1,1,0,0,0,0));
        tbl.push_back(mk(1,1,4'hF,B+4,2,2, 1,1,0,0,1,2));
        tbl.push_back(mk(1,1,4'hF,B,'1,2, 1,1,0,0,1,2));
        tbl.push_back(mk(1,0,4'hF,B,0,2, 1,1,2,0,1,2));
        tbl.push_back(mk(0,0,4'h0,0,0,0, 0,0,0,0,0,0));
        // masked source still pends
        tbl.push_back(mk(0,0,4'h0,0,0,1, 0,0,0,0,0,0));
        tbl.push_back(mk(1,1,4'hF,B+4,3,1, 1,1,0,0,1,1));
        tbl.push_back(mk(0,0,4'h0,0,0,0, 0,0,0,0,0,0));
        // two edges, two claims in priority order
        tbl.push_back(mk(1,1,4'hF,B+8,15,0, 1,1,0,0,0,0));
        tbl.push_back(mk(1,1,4'hF,B+4,15,0, 1,1,0,0,0,0));
        tbl.push_back(mk(0,0,4'h0,0,0,12, 0,0,0,0,1,3));
        tbl.push_back(mk(1,0,4'hF,B+12,0,12, 1,1,3,0,1,4));
        tbl.push_back(mk(1,0,4'hF,B+12,0,0, 1,1,4,0,0,0));
        // edge and W1C together: set wins
        tbl.push_back(mk(1,1,4'hF,B,1,1, 1,1,0,0,1,1));
        tbl.push_back(mk(1,1,4'hF,B,1,1, 1,1,0,0,0,0));
        // mode switch takes effect next cycle
        tbl.push_back(mk(0,0,4'h0,0,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(0,0,4'h0,0,0,1, 0,0,0,0,1,1));
        tbl.push_back(mk(1,1,4'hF,B+8,0,0, 1,1,0,0,1,1));
        tbl.push_back(mk(0,0,4'h0,0,0,0, 0,0,0,0,0,0));

        foreach (tbl[k]) begin
            bus.req   = tbl[k].req;
            bus.we    = tbl[k].we;
            bus.be    = tbl[k].be;
            bus.addr  = tbl[k].addr;
            bus.wdata = tbl[k].wdata;
            src       = tbl[k].src;
            #1;
            chk($sformatf("v%0d gnt", k),
                32'(bus.gnt), 32'(tbl[k].gnt));
            tick();
            chk($sformatf("v%0d rvalid", k),
                32'(bus.rvalid), 32'(tbl[k].rvalid));
            if (tbl[k].rvalid) begin
                chk($sformatf("v%0d rdata", k),
                    bus.rdata, tbl[k].rdata);
                chk($sformatf("v%0d err", k),
                    32'(bus.err), 32'(tbl[k].err));
            end
            chk($sformatf("v%0d irq", k),
                32'(irq), 32'(tbl[k].irq));
            chk($sformatf("v%0d id", k),
                32'(id), 32'(tbl[k].id));
        end
        bus.req = 1'b0;

        // reset in the middle of a granted read
        src = 4'h1;
        tick();
        chk("pre-rst irq", 32'(irq), 32'd1);
        bus.req  = 1'b1;
        bus.we   = 1'b0;
        bus.addr = B;
        #1;
        Rst = 1'b1;
        #1;
        chk("rst gnt", 32'(bus.gnt), 32'd1);
        chk("rst irq async", 32'(irq), 32'd0);
        chk("rst id async", 32'(id), 32'd0);
        tick();
        chk("in-rst rvalid", 32'(bus.rvalid), 32'd0);
        bus.req = 1'b0;
        Rst = 1'b0;
        tick();
        chk("post-rst rvalid", 32'(bus.rvalid), 32'd0);
        chk("post-rst irq", 32'(irq), 32'd0);
        rd_chk("post-rst pend", B, 32'd1);
        rd_chk("post-rst en", B + 4, 32'd0);
        rd_chk("post-rst edge", B + 8, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end
endmodule
